// File: rtl/regfile_param.sv
// Parameterised 2-read/1-write register file with a self-clearing sweep after reset or clr_req.
// Optional REGFILE_BYPASS_EN: same-cycle write-through from wd to matching read ports.
module regfile_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              ready
);

  localparam int unsigned       DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_clr_ptr;
  logic [ADDR_W-1:0]   w_clr_ptr_nxt;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [DATA_W-1:0]   w_mem_data;
  logic                w_wa_ok;

  // Entry 0 is hardwired to zero when ZERO_REG is set.
  assign w_wa_ok = !((ZERO_REG != 0) && (wa == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= CLEAR;
      r_clr_ptr <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_clr_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    w_mem_we      = 1'b0;
    w_mem_addr    = wa;
    w_mem_data    = wd;
    case (r_state)
      CLEAR: begin
        w_mem_we   = 1'b1;
        w_mem_addr = r_clr_ptr;
        w_mem_data = '0;
        // Pointer holds at the last entry; the restart value is loaded on clr_req.
        if (r_clr_ptr == LAST_PTR) begin
          w_state_nxt = READY;
        end else begin
          w_clr_ptr_nxt = r_clr_ptr + ADDR_W'(1);
        end
      end
      READY: begin
        w_mem_we = we && w_wa_ok;
        if (clr_req) begin
          w_state_nxt   = CLEAR;
          w_clr_ptr_nxt = '0;
        end
      end
      default: begin
        w_state_nxt   = CLEAR;
        w_clr_ptr_nxt = '0;
      end
    endcase
  end

  // Array is not reset; the sweep zeroes it.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_data;
    end
  end

  assign ready = (r_state == READY);

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] ra);
    logic [DATA_W-1:0] v;
    v = '0;
    if (r_state == READY) begin
      if ((ZERO_REG != 0) && (ra == '0)) begin
        v = '0;
`ifdef REGFILE_BYPASS_EN
      end else if (we && (wa == ra)) begin
        v = wd;
`endif
      end else begin
        v = r_mem[ra];
      end
    end
    return v;
  endfunction

  always_comb begin
    rd1 = read_port(ra1);
    rd2 = read_port(ra2);
  end

endmodule

// File: tb/tb_regfile_param.sv
// Directed self-checking bench for regfile_param with default parameters.
module tb_regfile_param;

  logic        clk;
  logic        rst_n;
  logic        clr_req;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        ready;

  int n_cmp;
  int n_fail;

  regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_req (clr_req),
    .we      (we),
    .wa      (wa),
    .wd      (wd),
    .ra1     (ra1),
    .ra2     (ra2),
    .rd1     (rd1),
    .rd2     (rd2),
    .ready   (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1;
    wa = a;
    wd = d;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr_req = 1'b0; we = 1'b0; wa = '0; wd = '0; ra1 = 5'd3; ra2 = 5'd17;
    #3;
    n_cmp++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", ready); end
    n_cmp++;
    if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
      n_fail++; $display("FAIL reset_rd: got %h/%h expected 0/0", rd1, rd2);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (ready !== (k == 32)) begin
        n_fail++; $display("FAIL reset_sweep_len cycle %0d: got ready=%b expected %b", k, ready, (k == 32));
      end
    end
  endtask

  task automatic test_all_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      ra1 = 5'(i);
      ra2 = 5'(31 - i);
      #1;
      n_cmp++;
      if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
        n_fail++; $display("FAIL %s_zero entry %0d: got %h/%h expected 0/0", tag, i, rd1, rd2);
      end
    end
  endtask

  task automatic test_write_read();
    wr(5'd5, 32'hDEADBEEF);
    wr(5'd0, 32'h00001234);
    wr(5'd31, 32'h0BADF00D);
    @(negedge clk);
    ra1 = 5'd5; ra2 = 5'd0;
    #1;
    n_cmp++;
    if (rd1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_rd_5: got %h expected deadbeef", rd1); end
    n_cmp++;
    if (rd2 !== 32'h0) begin n_fail++; $display("FAIL zero_reg: got %h expected 0", rd2); end
    @(negedge clk);
    ra1 = 5'd31; ra2 = 5'd31;
    #1;
    n_cmp++;
    if (rd1 !== 32'h0BADF00D) begin n_fail++; $display("FAIL wr_rd_31: got %h expected 0badf00d", rd1); end
    n_cmp++;
    if (rd2 !== rd1 || rd2 !== 32'h0BADF00D) begin
      n_fail++; $display("FAIL same_addr_ports: got %h/%h expected 0badf00d", rd1, rd2);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_same;
    wr(5'd3, 32'h11111111);
`ifdef REGFILE_BYPASS_EN
    exp_same = 32'hA5A5A5A5;
`else
    exp_same = 32'h11111111;
`endif
    @(negedge clk);
    we = 1'b1; wa = 5'd3; wd = 32'hA5A5A5A5; ra1 = 5'd3; ra2 = 5'd5;
    #1;
    n_cmp++;
    if (rd1 !== exp_same) begin n_fail++; $display("FAIL same_cycle_rd1: got %h expected %h", rd1, exp_same); end
    n_cmp++;
    if (rd2 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL other_port_during_wr: got %h expected deadbeef", rd2); end
    @(posedge clk);
    #1;
    we = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (rd1 !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL next_cycle_rd1: got %h expected a5a5a5a5", rd1); end
  endtask

  task automatic test_clear();
    for (int i = 1; i < 32; i++) wr(5'(i), {8'(i), 24'hC0FFEE});
    @(negedge clk);
    ra1 = 5'd20; ra2 = 5'd9;
    #1;
    n_cmp++;
    if (rd1 !== 32'h14C0FFEE) begin n_fail++; $display("FAIL fill_20: got %h expected 14c0ffee", rd1); end
    // clr_req together with a write: write lands, then the sweep erases it
    clr_req = 1'b1; we = 1'b1; wa = 5'd9; wd = 32'hFFFF0000;
    @(posedge clk);
    #1;
    clr_req = 1'b0; we = 1'b0;
    n_cmp++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL clr_ready_drop: got %b expected 0", ready); end
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      clr_req = (k == 5);
      we      = (k == 5);
      wa      = 5'd7;
      wd      = 32'h77777777;
      @(posedge clk);
      #1;
      clr_req = 1'b0; we = 1'b0;
      n_cmp++;
      if (ready !== (k == 32)) begin
        n_fail++; $display("FAIL clr_sweep_len cycle %0d: got ready=%b expected %b", k, ready, (k == 32));
      end
      if (k < 32) begin
        n_cmp++;
        if (rd1 !== 32'h0) begin n_fail++; $display("FAIL rd_gated cycle %0d: got %h expected 0", k, rd1); end
      end
    end
    test_all_zero("clr");
  endtask

  task automatic test_reset_mid();
    wr(5'd12, 32'hCAFEBABE);
    @(negedge clk);
    ra1 = 5'd12;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL async_rst_ready: got %b expected 0", ready); end
    n_cmp++;
    if (rd1 !== 32'h0) begin n_fail++; $display("FAIL async_rst_rd1: got %h expected 0", rd1); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (32) @(posedge clk);
    #1;
    n_cmp++;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL rst_resweep: got %b expected 1", ready); end
    wr(5'd10, 32'h5A5A5A5A);
    @(negedge clk);
    clr_req = 1'b1;
    @(posedge clk);
    #1;
    clr_req = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ready !== 1'b0 || rd1 !== 32'h0) begin
      n_fail++; $display("FAIL mid_sweep_rst: got ready=%b rd1=%h expected 0/0", ready, rd1);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (ready !== (k == 32)) begin
        n_fail++; $display("FAIL mid_rst_sweep_len cycle %0d: got ready=%b expected %b", k, ready, (k == 32));
      end
    end
    test_all_zero("mid_rst");
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_all_zero("init");
    test_write_read();
    test_bypass();
    test_clear();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 Parameter DATA_W, default 32: register width in bits.
REQ-002 Parameter ADDR_W, default 5: address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter ZERO_REG, default 1: 1 = entry 0 reads 0 and ignores writes; 0 = entry 0 is an ordinary register.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 clr_req  input  1  one-cycle pulse requesting a full clear of the array; honoured only in READY.
REQ-007 we  input  1  write enable.
REQ-008 wa  input  ADDR_W  write address.
REQ-009 wd  input  DATA_W  write data.
REQ-010 ra1, ra2  input  ADDR_W  read addresses, ports 1 and 2.
REQ-011 rd1, rd2  output  DATA_W  read data, ports 1 and 2, combinational from the addresses.
REQ-012 ready  output  1  high when the array is initialised and accepts writes.

Function
REQ-013 The FSM SHALL have two states: CLEAR and READY.
REQ-014 In CLEAR, the 2-state FSM SHALL write 0 to entry clr_ptr on each clock and increment clr_ptr, starting from 0.
REQ-015 CLEAR SHALL go to READY on the cycle after clr_ptr = DEPTH-1 is written, which takes exactly DEPTH cycles; ready SHALL rise on that edge.
REQ-016 READY SHALL go to CLEAR when clr_req=1, with clr_ptr reset to 0 and ready low from the next edge.
REQ-017 In READY, when we=1 the block SHALL write wd to entry wa on the rising edge, except wa=0 when ZERO_REG=1.
REQ-018 In CLEAR, we SHALL be ignored; external writes are dropped, not queued.
REQ-019 While ready=0, rd1 and rd2 SHALL be 0 regardless of the array contents.
REQ-020 While ready=1, rdN SHALL equal the entry at raN, and 0 if raN=0 with ZERO_REG=1.
REQ-021 If clr_req and we are both asserted in READY, the write SHALL complete on that edge and the clear SHALL then overwrite it.
REQ-022 clr_req asserted in CLEAR SHALL be ignored; the sweep does not restart.
REQ-023 When ra1 = ra2, both ports SHALL return identical data.
REQ-024 clr_ptr SHALL be ADDR_W bits wide and SHALL NOT wrap past DEPTH-1 in CLEAR.

Reset
REQ-025 When rst_n=0, the block SHALL immediately force state=CLEAR, clr_ptr=0, ready=0 and rd1=rd2=0, without waiting for a clock edge.
REQ-026 Array contents SHALL NOT be reset directly; they are zeroed by the CLEAR sweep that starts on the first clock edge after rst_n rises.
REQ-027 When rst_n is asserted mid-sweep or mid-write, the block SHALL abort the operation and restart the sweep from entry 0.

Configuration
REQ-028 With macro REGFILE_BYPASS_EN defined, in READY with we=1 and wa=raN (and wa≠0 when ZERO_REG=1), rdN SHALL return wd combinationally in the same cycle (write-through).
REQ-029 Without REGFILE_BYPASS_EN, rdN SHALL return the old entry contents during a same-address write; the new value appears from the next cycle.

Verification
REQ-030 Release rst_n with default parameters -> ready=0 for exactly 32 cycles, ready=1 on cycle 32, and every entry reads 0.
REQ-031 In READY, write we=1, wa=5, wd=32'hDEADBEEF, then set ra1=5 -> rd1=32'hDEADBEEF; write wa=0, wd=32'h1234 -> rd2 at ra2=0 reads 0.
REQ-032 Same-cycle we=1, wa=3, wd=32'hA5A5A5A5, ra1=3 -> rd1=32'hA5A5A5A5 in that cycle with BYPASS_EN; with it undefined, rd1 = old value, then 32'hA5A5A5A5 next cycle.
REQ-033 Fill entries 1..31 with nonzero values, pulse clr_req -> ready drops next cycle, stays low 32 cycles, then all entries read 0.
REQ-034 Assert rst_n=0 at clr_ptr=10 during CLEAR -> ready and outputs go 0 immediately; after release, ready rises exactly 32 cycles later.
REQ-035 Pulse we=1, wa=7 during CLEAR -> entry 7 reads 0 after ready rises.
